// File: rtl/top_mod2_pkg.sv
// Shared constants, Viterbi state encoding and the block-deinterleave address map
// for the receive-side burst decoder.
package top_mod2_pkg;

  localparam int WORDS      = 32;
  localparam int CODED_BITS = 128;
  localparam int MSG_BITS   = 62;
  localparam int PM_W       = 16;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef enum logic [2:0] {
    VS_IDLE  = 3'd0,
    VS_ACS   = 3'd1,
    VS_TRACE = 3'd2,
    VS_DONE  = 3'd3
  } vit_state_e;

  // 8x16 block read by columns: j -> (j mod 8)*16 + j/8
  function automatic logic [6:0] deint_idx(input logic [6:0] j);
    return {j[2:0], j[6:3]};
  endfunction

endpackage

// File: rtl/top_mod2_viterbi_k3_decoder.sv
// Rate-1/2, K=3 hard-decision Viterbi core: one ACS per symbol pair, then a
// 64-cycle traceback from state 0 into the decoded message register.
module viterbi_k3_decoder
  import top_mod2_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          sym_i,
  input  logic                sym_vld_i,
  output logic [MSG_BITS-1:0] dec_o,
  output logic                dec_vld_o,
  output logic [2:0]          state_o,
  output logic [8:0]          cnt_o,
  output logic [PM_W-1:0]     pm0_o,
  output logic [PM_W-1:0]     pm1_o
);

  vit_state_e          state_q;
  logic [8:0]          cnt_q;
  logic [PM_W-1:0]     pm_q [4];
  logic [3:0]          surv_q [64];
  logic [1:0]          tb_q;
  logic [MSG_BITS-1:0] dec_q;

  logic [PM_W-1:0] pm_src [4];
  logic [PM_W-1:0] pm_d [4];
  logic [PM_W-1:0] m_a [4];
  logic [PM_W-1:0] m_b [4];
  logic [3:0]      dvec_d;
  logic [5:0]      t_idx;
  logic [1:0]      tb_prev;

  function automatic logic [1:0] bm(input logic [1:0] s, input logic u, input logic [1:0] sym);
    logic [2:0] r;
    r = {u, s};
    return {1'b0, ^(G0 & r) ^ sym[1]} + {1'b0, ^(G1 & r) ^ sym[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? '1 : s[PM_W-1:0];
  endfunction

  // Outside ACS the metrics come from the start-in-state-0 initial values
  always_comb begin
    dvec_d = '0;
    for (int n = 0; n < 4; n++) begin
      pm_src[n] = (state_q == VS_ACS) ? pm_q[n] : ((n == 0) ? '0 : PM_W'(8'hFF));
    end
    for (int n = 0; n < 4; n++) begin
      m_a[n] = sat_add(pm_src[2*(n%2)],     bm(2'(2*(n%2)),     1'(n/2), sym_i));
      m_b[n] = sat_add(pm_src[2*(n%2) + 1], bm(2'(2*(n%2) + 1), 1'(n/2), sym_i));
      if (m_b[n] < m_a[n]) begin
        pm_d[n]   = m_b[n];
        dvec_d[n] = 1'b1;
      end else begin
        pm_d[n] = m_a[n];
      end
    end
  end

  assign t_idx   = 6'd63 - cnt_q[5:0];
  assign tb_prev = {tb_q[0], surv_q[t_idx][tb_q]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= VS_IDLE;
      cnt_q   <= '0;
      tb_q    <= '0;
      dec_q   <= '0;
      for (int i = 0; i < 4; i++) pm_q[i] <= '0;
      for (int i = 0; i < 64; i++) surv_q[i] <= '0;
    end else begin
      case (state_q)
        VS_ACS: begin
          if (sym_vld_i) begin
            pm_q                 <= pm_d;
            surv_q[cnt_q[5:0]]   <= dvec_d;
            if (cnt_q == 9'd63) begin
              state_q <= VS_TRACE;
              cnt_q   <= '0;
              tb_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        VS_TRACE: begin
          if (t_idx < 6'(MSG_BITS)) dec_q[t_idx] <= tb_q[1];
          tb_q <= tb_prev;
          if (cnt_q == 9'd63) state_q <= VS_DONE;
          else                cnt_q   <= cnt_q + 9'd1;
        end
        VS_DONE: ;
        default: begin
          if (sym_vld_i) begin
            pm_q      <= pm_d;
            surv_q[0] <= dvec_d;
            cnt_q     <= 9'd1;
            state_q   <= VS_ACS;
          end
        end
      endcase
    end
  end

  assign dec_o     = dec_q;
  assign dec_vld_o = (state_q == VS_DONE);
  assign state_o   = state_q;
  assign cnt_o     = cnt_q;
  assign pm0_o     = pm_q[0];
  assign pm1_o     = pm_q[1];

endmodule

// File: rtl/top_mod2.sv
// Burst decoder top: captures 32 four-bit words, column-reads the 8x16 block
// serially, pairs the bits into symbols and feeds the Viterbi core.
module top_mod2
  import top_mod2_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          file_in_bits,
  input  logic                data_ready,
  output logic [MSG_BITS-1:0] decoded_data,
  output logic                decoded_valid,
  output logic                deint_out,
  output logic                deint_out_valid,
  output logic [1:0]          vitebri_data_in,
  output logic                vitebri_valid_in,
  output logic [2:0]          vitebri_state,
  output logic [8:0]          vitebri_counter,
  output logic [PM_W-1:0]     PM0_debug,
  output logic [PM_W-1:0]     PM1_debug
);

  logic [CODED_BITS-1:0] buf_q;
  logic [5:0]            wcnt_q;
  logic                  run_q;
  logic [6:0]            dcnt_q;
  logic                  first_q;
  logic [1:0]            pair_q;
  logic                  pvld_q;
  logic                  dbit;

  assign dbit = buf_q[deint_idx(dcnt_q)];

  // wcnt_q saturates at WORDS, so later strobes are dropped until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      wcnt_q  <= '0;
      run_q   <= 1'b0;
      dcnt_q  <= '0;
      first_q <= 1'b0;
      pair_q  <= '0;
      pvld_q  <= 1'b0;
    end else begin
      if (data_ready && (wcnt_q < 6'(WORDS))) begin
        for (int i = 0; i < 4; i++) buf_q[{wcnt_q[4:0], 2'(i)}] <= file_in_bits[2'(3 - i)];
        wcnt_q <= wcnt_q + 6'd1;
        if (wcnt_q == 6'(WORDS - 1)) begin
          run_q  <= 1'b1;
          dcnt_q <= '0;
        end
      end
      pvld_q <= 1'b0;
      if (run_q) begin
        dcnt_q <= dcnt_q + 7'd1;
        if (!dcnt_q[0]) begin
          first_q <= dbit;
        end else begin
          pair_q <= {first_q, dbit};
          pvld_q <= 1'b1;
        end
        if (dcnt_q == 7'd127) run_q <= 1'b0;
      end
    end
  end

  assign deint_out        = run_q & dbit;
  assign deint_out_valid  = run_q;
  assign vitebri_data_in  = pair_q;
  assign vitebri_valid_in = pvld_q;

  viterbi_k3_decoder u_vit (
    .clk       (clk),
    .reset     (reset),
    .sym_i     (pair_q),
    .sym_vld_i (pvld_q),
    .dec_o     (decoded_data),
    .dec_vld_o (decoded_valid),
    .state_o   (vitebri_state),
    .cnt_o     (vitebri_counter),
    .pm0_o     (PM0_debug),
    .pm1_o     (PM1_debug)
  );

endmodule

// File: tb/tb_top_mod2.sv
// Directed bench for the burst decoder: hand-built interleaved bursts with
// known decode results, reset aborts and post-burst strobe rejection.
module tb_top_mod2;

  logic        clk;
  logic        reset;
  logic [3:0]  file_in_bits;
  logic        data_ready;
  logic [61:0] decoded_data;
  logic        decoded_valid;
  logic        deint_out;
  logic        deint_out_valid;
  logic [1:0]  vitebri_data_in;
  logic        vitebri_valid_in;
  logic [2:0]  vitebri_state;
  logic [8:0]  vitebri_counter;
  logic [15:0] PM0_debug;
  logic [15:0] PM1_debug;

  top_mod2 dut (
    .clk              (clk),
    .reset            (reset),
    .file_in_bits     (file_in_bits),
    .data_ready       (data_ready),
    .decoded_data     (decoded_data),
    .decoded_valid    (decoded_valid),
    .deint_out        (deint_out),
    .deint_out_valid  (deint_out_valid),
    .vitebri_data_in  (vitebri_data_in),
    .vitebri_valid_in (vitebri_valid_in),
    .vitebri_state    (vitebri_state),
    .vitebri_counter  (vitebri_counter),
    .PM0_debug        (PM0_debug),
    .PM1_debug        (PM1_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int dv_cnt  = 0;
  int hi_cnt  = 0;
  int hi_last = 0;
  int vp_cnt  = 0;
  logic [1:0] ph [0:1023];

  always @(negedge clk) begin
    if (deint_out_valid) begin
      if (deint_out) begin
        hi_cnt  = hi_cnt + 1;
        hi_last = dv_cnt;
      end
      dv_cnt = dv_cnt + 1;
    end
    if (vitebri_valid_in) begin
      ph[vp_cnt % 1024] = vitebri_data_in;
      vp_cnt = vp_cnt + 1;
    end
  end

  logic [3:0] burst [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_burst();
    for (int w = 0; w < 32; w++) burst[w] = 4'h0;
  endtask

  task automatic send_burst(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      @(negedge clk);
      data_ready   = 1'b1;
      file_in_bits = burst[w];
    end
    @(negedge clk);
    data_ready   = 1'b0;
    file_in_bits = 4'h0;
  endtask

  // Counts clock edges after the one that accepted the last word
  task automatic wait_done(input int extra, output int lat);
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c <= extra) begin
        data_ready   = 1'b1;
        file_in_bits = 4'hF;
      end else begin
        data_ready   = 1'b0;
        file_in_bits = 4'h0;
      end
      if (decoded_valid) begin
        lat = c;
        break;
      end
    end
    data_ready   = 1'b0;
    file_in_bits = 4'h0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int lat;
  int b_dv, b_hi, b_vp;

  initial begin
    reset        = 1'b0;
    data_ready   = 1'b0;
    file_in_bits = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_valid",   64'(decoded_valid), 64'd0);
    chk("rst_data",    64'(decoded_data), 64'd0);
    chk("rst_state",   64'(vitebri_state), 64'd0);
    chk("rst_counter", 64'(vitebri_counter), 64'd0);
    chk("rst_pm0",     64'(PM0_debug), 64'd0);
    chk("rst_pm1",     64'(PM1_debug), 64'd0);
    chk("rst_dvalid",  64'(deint_out_valid), 64'd0);
    chk("rst_vvalid",  64'(vitebri_valid_in), 64'd0);
    reset = 1'b1;

    // All-zero burst
    clear_burst();
    b_dv = dv_cnt; b_hi = hi_cnt; b_vp = vp_cnt;
    send_burst(32);
    wait_done(0, lat);
    chk("zero_latency", 64'((lat >= 1) && (lat <= 196)), 64'd1);
    chk("zero_data",    64'(decoded_data), 64'd0);
    chk("zero_pm0",     64'(PM0_debug), 64'd0);
    chk("zero_state",   64'(vitebri_state), 64'd3);
    chk("zero_dv_cnt",  64'(dv_cnt - b_dv), 64'd128);
    chk("zero_hi_cnt",  64'(hi_cnt - b_hi), 64'd0);
    chk("zero_vp_cnt",  64'(vp_cnt - b_vp), 64'd64);

    // Message bit0=1: coded bits 0,1,2,4,5 set -> buf 0,16,32,64,80 (bit3 of words 0,4,8,16,20)
    reset_dut();
    clear_burst();
    burst[0] = 4'h8; burst[4] = 4'h8; burst[8] = 4'h8; burst[16] = 4'h8; burst[20] = 4'h8;
    send_burst(32);
    wait_done(0, lat);
    chk("msg1_valid", 64'(decoded_valid), 64'd1);
    chk("msg1_data",  64'(decoded_data), 64'h1);
    chk("msg1_pm0",   64'(PM0_debug), 64'd0);

    // Same with coded bit 10 flipped -> buf 33 -> word 8 bit2
    reset_dut();
    burst[8] = 4'hC;
    send_burst(32);
    wait_done(0, lat);
    chk("flip_valid", 64'(decoded_valid), 64'd1);
    chk("flip_data",  64'(decoded_data), 64'h1);
    chk("flip_pm0",   64'(PM0_debug), 64'd1);

    // Only buf[16] set -> deint bit j=1 alone
    reset_dut();
    clear_burst();
    burst[4] = 4'h8;
    b_dv = dv_cnt; b_hi = hi_cnt; b_vp = vp_cnt;
    send_burst(32);
    wait_done(0, lat);
    chk("ord_hi_cnt",     64'(hi_cnt - b_hi), 64'd1);
    chk("ord_hi_pos",     64'(hi_last - b_dv), 64'd1);
    chk("ord_first_pair", 64'(ph[b_vp % 1024]), 64'(2'b01));
    chk("ord_vp_cnt",     64'(vp_cnt - b_vp), 64'd64);

    // Asynchronous reset while DONE clears outputs without a clock edge
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 64'(decoded_valid), 64'd0);
    chk("async_state", 64'(vitebri_state), 64'd0);
    chk("async_data",  64'(decoded_data), 64'd0);
    data_ready   = 1'b1;
    file_in_bits = 4'hF;
    @(negedge clk);
    data_ready   = 1'b0;
    file_in_bits = 4'h0;
    reset = 1'b1;

    // Abort after 20 words, then a clean zero burst
    for (int w = 0; w < 32; w++) burst[w] = 4'hF;
    send_burst(20);
    #2 reset = 1'b0;
    #1;
    chk("abort_dvalid", 64'(deint_out_valid), 64'd0);
    chk("abort_valid",  64'(decoded_valid), 64'd0);
    chk("abort_pm0",    64'(PM0_debug), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_burst();
    send_burst(32);
    wait_done(0, lat);
    chk("abort_latency", 64'((lat >= 1) && (lat <= 196)), 64'd1);
    chk("abort_data",    64'(decoded_data), 64'd0);
    chk("abort_pm0b",    64'(PM0_debug), 64'd0);

    // Extra strobes after word 32 are dropped; result held until reset
    reset_dut();
    clear_burst();
    send_burst(32);
    wait_done(5, lat);
    chk("extra_latency", 64'((lat >= 1) && (lat <= 196)), 64'd1);
    chk("extra_data",    64'(decoded_data), 64'd0);
    chk("extra_pm0",     64'(PM0_debug), 64'd0);
    repeat (20) @(negedge clk);
    chk("hold_valid", 64'(decoded_valid), 64'd1);
    chk("hold_data",  64'(decoded_data), 64'd0);
    chk("hold_state", 64'(vitebri_state), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
